// File: rtl/sine_sweep_pkg.sv
// Shared types and constants for the sine sweep controller.
// Holds the FSM state encoding, sweep mode codes and default widths.
package sine_sweep_pkg;

    localparam int DEFAULT_PHASE_WIDTH = 32;
    localparam int DEFAULT_DWELL_WIDTH = 16;

    localparam logic [1:0] MODE_SINGLE = 2'd0;
    localparam logic [1:0] MODE_SAW    = 2'd1;
    localparam logic [1:0] MODE_TRI    = 2'd2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN_UP   = 2'd1,
        RUN_DOWN = 2'd2
    } sweep_state_e;

    // The reserved mode code behaves like a single sweep.
    function automatic logic [1:0] normalize_mode(input logic [1:0] mode);
        return (mode == 2'd3) ? MODE_SINGLE : mode;
    endfunction

endpackage

// File: rtl/sweep_dwell_timer.sv
// Dwell interval counter: pulses o_terminal on the last cycle of every
// max(dwell,1)-cycle interval while enabled; cleared back to zero on i_clear.
module sweep_dwell_timer #(
    parameter int DWELL_WIDTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_clear,
    input  logic                   i_enable,
    input  logic [DWELL_WIDTH-1:0] i_dwell,
    output logic                   o_terminal
);

    logic [DWELL_WIDTH-1:0] count_reg;
    logic [DWELL_WIDTH-1:0] last_count;

    // A dwell of zero is treated as one cycle per step.
    assign last_count = (i_dwell == '0) ? '0 : i_dwell - DWELL_WIDTH'(1);
    assign o_terminal = i_enable && !i_clear && (count_reg == last_count);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_reg <= '0;
        end else if (i_clear) begin
            count_reg <= '0;
        end else if (i_enable) begin
            count_reg <= o_terminal ? '0 : count_reg + DWELL_WIDTH'(1);
        end
    end

endmodule

// File: rtl/sine_sweep_controller.sv
// Chirp sequencer: latches a sweep configuration on start and steps the
// generator phase increment every dwell interval in single/saw/triangle mode.
module sine_sweep_controller
    import sine_sweep_pkg::*;
#(
    parameter int PHASE_WIDTH = DEFAULT_PHASE_WIDTH,
    parameter int DWELL_WIDTH = DEFAULT_DWELL_WIDTH
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic                   i_abort,
    input  logic [1:0]             i_mode,
    input  logic [PHASE_WIDTH-1:0] i_start_inc,
    input  logic [PHASE_WIDTH-1:0] i_stop_inc,
    input  logic [PHASE_WIDTH-1:0] i_step,
    input  logic [DWELL_WIDTH-1:0] i_dwell,
    output logic [PHASE_WIDTH-1:0] o_phase_adder,
    output logic                   o_gen_rst,
    output logic                   o_busy,
    output logic                   o_step_tick,
    output logic                   o_done,
    output logic                   o_cfg_err
);

    sweep_state_e           state_reg, state_next;
    logic [PHASE_WIDTH-1:0] cur_reg, cur_next;
    logic [PHASE_WIDTH-1:0] start_reg, stop_reg, step_reg;
    logic [DWELL_WIDTH-1:0] dwell_reg;
    logic [1:0]             mode_reg;
    logic                   load_cfg;
    logic                   tick_next, done_next, err_next;
    logic                   dwell_tc;

    logic [PHASE_WIDTH:0]   up_sum, down_diff;
    logic                   up_ok, down_ok;

    // One extra bit catches carry past the top and borrow below zero.
    assign up_sum    = {1'b0, cur_reg} + {1'b0, step_reg};
    assign down_diff = {1'b0, cur_reg} - {1'b0, step_reg};
    assign up_ok     = !up_sum[PHASE_WIDTH] && (up_sum[PHASE_WIDTH-1:0] <= stop_reg);
    assign down_ok   = !down_diff[PHASE_WIDTH] && (down_diff[PHASE_WIDTH-1:0] >= start_reg);

    sweep_dwell_timer #(
        .DWELL_WIDTH(DWELL_WIDTH)
    ) u_dwell_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clear    ((state_reg == IDLE) || i_abort),
        .i_enable   (state_reg != IDLE),
        .i_dwell    (dwell_reg),
        .o_terminal (dwell_tc)
    );

    always_comb begin
        state_next = state_reg;
        cur_next   = cur_reg;
        load_cfg   = 1'b0;
        tick_next  = 1'b0;
        done_next  = 1'b0;
        err_next   = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (i_start && !i_abort) begin
                    if ((i_step == '0) || (i_start_inc > i_stop_inc)) begin
                        err_next = 1'b1;
                    end else begin
                        load_cfg   = 1'b1;
                        cur_next   = i_start_inc;
                        state_next = RUN_UP;
                    end
                end
            end
            RUN_UP: begin
                if (i_abort) begin
                    state_next = IDLE;
                end else if (dwell_tc) begin
                    if (up_ok) begin
                        cur_next  = up_sum[PHASE_WIDTH-1:0];
                        tick_next = 1'b1;
                    end else if (mode_reg == MODE_SAW) begin
                        // Wrapping onto the value already shown is not a change.
                        cur_next  = start_reg;
                        tick_next = (cur_reg != start_reg);
                    end else if (mode_reg == MODE_TRI) begin
                        if (down_ok) begin
                            cur_next   = down_diff[PHASE_WIDTH-1:0];
                            state_next = RUN_DOWN;
                            tick_next  = 1'b1;
                        end
                    end else begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            RUN_DOWN: begin
                if (i_abort) begin
                    state_next = IDLE;
                end else if (dwell_tc) begin
                    if (down_ok) begin
                        cur_next  = down_diff[PHASE_WIDTH-1:0];
                        tick_next = 1'b1;
                    end else if (up_ok) begin
                        cur_next   = up_sum[PHASE_WIDTH-1:0];
                        state_next = RUN_UP;
                        tick_next  = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= IDLE;
            cur_reg   <= '0;
            start_reg <= '0;
            stop_reg  <= '0;
            step_reg  <= '0;
            dwell_reg <= '0;
            mode_reg  <= MODE_SINGLE;
        end else begin
            state_reg <= state_next;
            cur_reg   <= cur_next;
            if (load_cfg) begin
                start_reg <= i_start_inc;
                stop_reg  <= i_stop_inc;
                step_reg  <= i_step;
                dwell_reg <= i_dwell;
                mode_reg  <= normalize_mode(i_mode);
            end
        end
    end

    // Outputs are registered from the next-state view so they line up with the state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_phase_adder <= '0;
            o_gen_rst     <= 1'b1;
            o_busy        <= 1'b0;
            o_step_tick   <= 1'b0;
            o_done        <= 1'b0;
            o_cfg_err     <= 1'b0;
        end else begin
            o_phase_adder <= (state_next == IDLE) ? '0 : cur_next;
            o_gen_rst     <= (state_next == IDLE);
            o_busy        <= (state_next != IDLE);
            o_step_tick   <= tick_next;
            o_done        <= done_next;
            o_cfg_err     <= err_next;
        end
    end

endmodule
